led_stream_driver: RTL and testbench
====================================

# led_stream_driver

Parametrised serial driver for WS2812-class addressable LED chains. It accepts a valid/ready pixel stream, serialises each pixel MSB-first with back-to-back bit periods, and frames each refresh with a latch (reset) low period. It replaces the fixed 24-bit, fixed-order driver with configurable pixel width (RGB or RGBW), timing and chain length. It sits between the colour-generation/frame-buffer logic and the LED output pin.

## Interface
- NUM_LEDS, 150 — pixels per frame, ≥1
- BITS_PER_LED, 24 — 24 (GRB) or 32 (GRBW); pixel word already in wire order
- SYSTEM_CLOCK, 50_000_000 — clk frequency, Hz
- T0H_NS, 400 / T1H_NS, 800 / BIT_NS, 1250 / LATCH_NS, 80000 — high time for 0, high time for 1, bit period, latch low time
- Derived cycles X_CYC = (SYSTEM_CLOCK/1_000_000)*X_NS/1000, integer floor; defaults give T0H_CYC=20, T1H_CYC=40, BIT_CYC=62, LATCH_CYC=4000
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle request to send one frame; ignored while busy
- pixel_data  in  BITS_PER_LED  pixel word, bit [BITS_PER_LED-1] sent first
- pixel_valid  in  1  pixel_data valid
- pixel_ready  out  1  driver accepts pixel this cycle (transfer = valid && ready)
- address  out  log2(NUM_LEDS)  index of next pixel to be accepted
- busy  out  1  frame in progress (including latch period)
- frame_done  out  1  one-cycle pulse at end of latch period
- underrun  out  1  sticky; set when a pixel is needed and holding register is empty; cleared by start
- DO  out  1  serial line to LED chain

## Operation
- Reset (asynchronous assert while reset=0): DO=0, pixel_ready=0, busy=0, frame_done=0, underrun=0, address=0, state IDLE, holding register empty. Reset mid-frame aborts immediately; DO low.
- Two storage stages: holding register (1 pixel) and shift register. pixel_ready = busy && holding empty && accepted count < NUM_LEDS.
- States:
  - IDLE: DO=0. start=1 → busy=1, address=0, underrun=0, → WAIT.
  - WAIT: DO=0. When holding full, move to shift register, → BIT.
  - BIT: bit counter 0..BIT_CYC-1. DO=1 while counter < THx_CYC (x = current MSB), else 0. At counter=BIT_CYC-1: if bits remain, shift left, stay BIT (next bit starts next cycle, no gap). If last bit of pixel: if pixels sent == NUM_LEDS → LATCH; else if holding full → load, stay BIT; else set underrun, → WAIT.
  - LATCH: DO=0 for LATCH_CYC cycles; on final cycle pulse frame_done, busy=0, → IDLE.
- address increments by 1 on each accepted transfer; saturates (holds) at NUM_LEDS-1 after last accept... last accept leaves address=NUM_LEDS-1; returns to 0 on next start.
- Extra pixels: pixel_ready stays low once NUM_LEDS accepted; no pixel dropped or double-accepted.
- start while busy: ignored, no effect on counters or flags.
- Underrun stall longer than LATCH_NS latches the chain early; driver still completes the frame; underrun stays set for software to see.

## Timing
- start sampled at edge N → busy=1 and pixel_ready=1 (if holding empty) at N+1.
- Pixel accepted at edge A in WAIT → shift register loaded A+1, DO rises A+2.
- Every bit exactly BIT_CYC cycles; 0-bit high T0H_CYC, 1-bit high T1H_CYC. Pixel-to-pixel and colour-to-colour gaps: 0 cycles when no underrun.
- Holding register refills during current pixel: pixel_ready reasserts the cycle after the holding register moves to the shift register.
- Frame length (no underrun) = NUM_LEDS*BITS_PER_LED*BIT_CYC + LATCH_CYC cycles from first DO rise to frame_done.
- frame_done high exactly 1 cycle; busy falls same edge.

## Test plan
- Defaults, NUM_LEDS=3, pixels 0xFF0000, 0x00FF00, 0x0000FF, valid always high → 72 bits each exactly 62 cycles, high 40 for 1s, 20 for 0s; LATCH low 4000 cycles; one frame_done; underrun=0.
- BITS_PER_LED=32, NUM_LEDS=2, pixels 0xA5A5A5A5, 0x00000001 → 64 bits, pattern matches MSB-first; last bit high 40 cycles.
- Underrun: NUM_LEDS=2, second pixel valid 500 cycles late → DO low during stall, underrun=1, second pixel sent intact, frame_done once.
- Pixel overrun: valid held high with 5 pixels, NUM_LEDS=3 → exactly 3 accepts, address sequence 0,1,2, pixel_ready low thereafter.
- start pulsed mid-frame → ignored; frame timing unchanged.
- reset asserted mid-bit (DO=1) → DO, busy, pixel_ready, address all 0 immediately (asynchronously); new start after release produces a clean full frame.

Source files
------------

// File: rtl/led_stream_driver.sv
// ---------------------------------------------------------------------------
// led_stream_driver
//
// Serial driver for WS2812-class addressable LED chains. Pixels arrive on a
// valid/ready stream and pass through a one-pixel holding register and a
// shift register. Each pixel goes out MSB-first with no gap between bit
// periods. Each refresh ends with a latch (reset) low period.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle request to send a frame (ignored while busy)
//   pixel_data_i   pixel word in wire order, bit [BITS_PER_LED-1] sent first
//   pixel_valid_i  pixel_data_i is valid
//   pixel_ready_o  driver accepts a pixel this cycle
//   address_o      index of the next pixel to be accepted
//   busy_o         frame in progress, including the latch period
//   frame_done_o   one-cycle pulse at the end of the latch period
//   underrun_o     sticky: a pixel was needed but the holding register was
//                  empty; cleared by start
//   do_o           serial line to the LED chain
// ---------------------------------------------------------------------------
module led_stream_driver #(
  parameter int NUM_LEDS     = 150,
  parameter int BITS_PER_LED = 24,
  parameter int SYSTEM_CLOCK = 50_000_000,
  parameter int T0H_NS       = 400,
  parameter int T1H_NS       = 800,
  parameter int BIT_NS       = 1250,
  parameter int LATCH_NS     = 80000,
  localparam int ADDR_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [BITS_PER_LED-1:0] pixel_data_i,
  input  logic                    pixel_valid_i,
  output logic                    pixel_ready_o,
  output logic [ADDR_W-1:0]       address_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    underrun_o,
  output logic                    do_o
);

  // state   | meaning
  // --------+-----------------------------------------------------------
  // S_IDLE  | no frame; DO low; waits for start
  // S_WAIT  | frame active, shift register empty; waits for a pixel
  // S_BIT   | shifting one bit period per BIT_CYC cycles
  // S_LATCH | all pixels sent; DO held low for the latch time

  localparam int CLK_MHZ   = SYSTEM_CLOCK / 1_000_000;
  localparam int T0H_CYC   = CLK_MHZ * T0H_NS / 1000;
  localparam int T1H_CYC   = CLK_MHZ * T1H_NS / 1000;
  localparam int BIT_CYC   = CLK_MHZ * BIT_NS / 1000;
  localparam int LATCH_CYC = CLK_MHZ * LATCH_NS / 1000;

  localparam int TMR_MAX = (LATCH_CYC > BIT_CYC - 1) ? LATCH_CYC : BIT_CYC - 1;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CNT_W   = $clog2(NUM_LEDS + 1);
  localparam int BCNT_W  = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;

  localparam logic [TMR_W-1:0]  BIT_LAST   = TMR_W'(BIT_CYC - 1);
  localparam logic [TMR_W-1:0]  T0H_C      = TMR_W'(T0H_CYC);
  localparam logic [TMR_W-1:0]  T1H_C      = TMR_W'(T1H_CYC);
  localparam logic [TMR_W-1:0]  LATCH_LOAD = TMR_W'(LATCH_CYC);
  localparam logic [CNT_W-1:0]  NUM_C      = CNT_W'(NUM_LEDS);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(BITS_PER_LED - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BIT   = 2'd2,
    S_LATCH = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [BCNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [BITS_PER_LED-1:0] shift_q, shift_d;
  logic [BITS_PER_LED-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic [CNT_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        sent_q, sent_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic                    underrun_q, underrun_d;
  logic                    frame_done_q, frame_done_d;
  logic                    do_q, do_d;

  logic                    accept;
  logic                    load_shift;
  logic [TMR_W-1:0]        elapsed;
  logic [TMR_W-1:0]        high_len;

  assign pixel_ready_o = busy_q && !hold_full_q && (acc_q < NUM_C);
  assign accept        = pixel_valid_i && pixel_ready_o;

  // Cycles spent in the current bit; only meaningful in S_BIT, where the
  // timer never exceeds BIT_LAST.
  assign elapsed  = BIT_LAST - timer_q;
  assign high_len = shift_q[BITS_PER_LED-1] ? T1H_C : T0H_C;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    acc_d        = acc_q;
    sent_d       = sent_q;
    addr_d       = addr_q;
    busy_d       = busy_q;
    underrun_d   = underrun_q;
    frame_done_d = 1'b0;
    do_d         = 1'b0;
    load_shift   = 1'b0;

    if (accept) begin
      hold_d      = pixel_data_i;
      hold_full_d = 1'b1;
      acc_d       = acc_q + CNT_W'(1);
      if (addr_q != ADDR_LAST) begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          busy_d     = 1'b1;
          addr_d     = '0;
          acc_d      = '0;
          sent_d     = '0;
          underrun_d = 1'b0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (hold_full_q) begin
          load_shift = 1'b1;
          state_d    = S_BIT;
        end
      end

      S_BIT: begin
        do_d = (elapsed < high_len);
        if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else if (bitcnt_q != '0) begin
          bitcnt_d = bitcnt_q - BCNT_W'(1);
          shift_d  = shift_q << 1;
          timer_d  = BIT_LAST;
        end else if (sent_q == NUM_C) begin
          // DO is registered one cycle behind the state, so the latch
          // counter runs LATCH_CYC+1 cycles to leave exactly LATCH_CYC
          // cycles of low on the wire after the last bit.
          state_d = S_LATCH;
          timer_d = LATCH_LOAD;
        end else if (hold_full_q) begin
          load_shift = 1'b1;
        end else begin
          underrun_d = 1'b1;
          state_d    = S_WAIT;
        end
      end

      S_LATCH: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TMR_W'(1);
        end else begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Accept and load are mutually exclusive: accept needs the holding
    // register empty, load needs it full.
    if (load_shift) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      sent_d      = sent_q + CNT_W'(1);
      bitcnt_d    = BCNT_LAST;
      timer_d     = BIT_LAST;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      acc_q        <= '0;
      sent_q       <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
      frame_done_q <= 1'b0;
      do_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      acc_q        <= acc_d;
      sent_q       <= sent_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
      frame_done_q <= frame_done_d;
      do_q         <= do_d;
    end
  end

  assign address_o    = addr_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign underrun_o   = underrun_q;
  assign do_o         = do_q;

endmodule

// File: tb/tb_led_stream_driver.sv
// ---------------------------------------------------------------------------
// tb_led_stream_driver
//
// Two driver instances: A (3 LEDs x 24 bits) and B (2 LEDs x 32 bits), both
// with default timing. A select signal routes stimulus to one instance and
// muxes its outputs to a shared monitor. The monitor decodes DO into bits
// and compares each bit against the pixel list offered by the stimulus.
// ---------------------------------------------------------------------------
module tb_led_stream_driver;

  localparam int MHZ   = 50_000_000 / 1_000_000;
  localparam int T0H   = MHZ * 400 / 1000;
  localparam int T1H   = MHZ * 800 / 1000;
  localparam int BITC  = MHZ * 1250 / 1000;
  localparam int LATCH = MHZ * 80000 / 1000;
  localparam int FRAME_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data = '0;

  logic       ready_a, busy_a, done_a, under_a, do_a;
  logic [1:0] addr_a;
  logic       ready_b, busy_b, done_b, under_b, do_b;
  logic [0:0] addr_b;

  logic       ready_m, busy_m, done_m, under_m, do_m;
  logic [7:0] addr_m;

  always #5 clk = ~clk;

  led_stream_driver #(.NUM_LEDS(3), .BITS_PER_LED(24)) u_dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start && !sel),
    .pixel_data_i (data[23:0]),
    .pixel_valid_i(valid && !sel),
    .pixel_ready_o(ready_a),
    .address_o    (addr_a),
    .busy_o       (busy_a),
    .frame_done_o (done_a),
    .underrun_o   (under_a),
    .do_o         (do_a)
  );

  led_stream_driver #(.NUM_LEDS(2), .BITS_PER_LED(32)) u_dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start && sel),
    .pixel_data_i (data),
    .pixel_valid_i(valid && sel),
    .pixel_ready_o(ready_b),
    .address_o    (addr_b),
    .busy_o       (busy_b),
    .frame_done_o (done_b),
    .underrun_o   (under_b),
    .do_o         (do_b)
  );

  always_comb begin
    if (sel) begin
      ready_m = ready_b; busy_m = busy_b; done_m = done_b;
      under_m = under_b; do_m = do_b; addr_m = {7'd0, addr_b};
    end else begin
      ready_m = ready_a; busy_m = busy_a; done_m = done_a;
      under_m = under_a; do_m = do_a; addr_m = {6'd0, addr_a};
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model state: pixels offered for the current frame.
  logic [31:0] pix_q[$];
  int cur_n = 3;
  int cur_b = 24;

  function automatic bit model_bit(input int k);
    int p;
    int b;
    p = k / cur_b;
    b = cur_b - 1 - (k % cur_b);
    if (p >= cur_n || p >= pix_q.size()) return 1'b0;
    return pix_q[p][b];
  endfunction

  // Monitor state
  int cyc = 0;
  int nbits, n_acc, n_done, ready_bad;
  int first_rise, prev_rise, done_cyc;
  bit do_prev = 1'b0;
  bit mon_en = 1'b0;
  bit allow_gap = 1'b0;

  task automatic mon_clear(input bit gap);
    nbits = 0; n_acc = 0; n_done = 0; ready_bad = 0;
    first_rise = 0; prev_rise = 0; done_cyc = 0;
    allow_gap = gap;
    mon_en = 1'b1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (ready_m && n_acc >= cur_n) ready_bad++;
      if (valid && ready_m) begin
        check_eq("address", int'(addr_m), n_acc);
        n_acc++;
      end
      if (do_m && !do_prev) begin
        if (nbits == 0) first_rise = cyc;
        else if (allow_gap && (nbits % cur_b) == 0)
          check_eq("gap_min", int'((cyc - prev_rise) >= BITC), 1);
        else
          check_eq("bit_period", cyc - prev_rise, BITC);
        prev_rise = cyc;
      end
      if (!do_m && do_prev) begin
        check_eq("bit_high", cyc - prev_rise, model_bit(nbits) ? T1H : T0H);
        nbits++;
      end
      if (done_m) begin
        n_done++;
        done_cyc = cyc;
        check_eq("busy_at_done", int'(busy_m), 0);
      end
    end
    do_prev = do_m;
  end

  task automatic start_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic rand_pix(input int n);
    pix_q.delete();
    for (int k = 0; k < n; k++) pix_q.push_back($urandom);
  endtask

  // late_cyc > 0 holds the second pixel back that many cycles;
  // poke_t >= 0 pulses start at that cycle of the frame.
  task automatic do_frame(input string nm, input bit s, input int count,
                          input int late_cyc, input bit rnd_gaps,
                          input int poke_t, input bit exp_under);
    int i;
    int t;
    int late_left;
    bit v;
    i = 0; t = 0;
    sel = s;
    cur_n = s ? 2 : 3;
    cur_b = s ? 32 : 24;
    late_left = late_cyc;
    mon_clear(late_cyc > 0);
    start_frame();
    while (n_done == 0 && t < FRAME_LIMIT) begin
      v = (i < count);
      if (late_left > 0 && i == 1) begin
        v = 1'b0;
        late_left--;
      end
      if (rnd_gaps && $urandom_range(0, 3) == 0) v = 1'b0;
      valid = v;
      if (v) data = pix_q[i];
      else   data = $urandom;
      start = (t == poke_t);
      @(negedge clk);
      if (t == 0) begin
        check_eq({nm, ":busy_after_start"}, int'(busy_m), 1);
        check_eq({nm, ":ready_after_start"}, int'(ready_m), 1);
      end
      if (valid && ready_m) i++;
      @(posedge clk); #1;
      t++;
    end
    valid = 1'b0;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq({nm, ":done_cnt"}, n_done, 1);
    check_eq({nm, ":bits"}, nbits, cur_n * cur_b);
    check_eq({nm, ":accepts"}, n_acc, cur_n);
    check_eq({nm, ":ready_extra"}, ready_bad, 0);
    if (late_cyc == 0)
      check_eq({nm, ":frame_len"}, done_cyc - first_rise, cur_n * cur_b * BITC + LATCH);
    else
      check_eq({nm, ":frame_long"},
               int'((done_cyc - first_rise) > cur_n * cur_b * BITC + LATCH), 1);
    check_eq({nm, ":underrun"}, int'(under_m), int'(exp_under));
    check_eq({nm, ":busy_end"}, int'(busy_m), 0);
    check_eq({nm, ":addr_end"}, int'(addr_m), cur_n - 1);
    mon_en = 1'b0;
  endtask

  int  t_r;
  int  i_r;
  bit  hit;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_eq("rst_do", int'(do_m), 0);
      check_eq("rst_busy", int'(busy_m), 0);
      check_eq("rst_ready", int'(ready_m), 0);
      check_eq("rst_done", int'(done_m), 0);
      check_eq("rst_under", int'(under_m), 0);
      check_eq("rst_addr", int'(addr_m), 0);
    end
    sel = 1'b0;
    #1 rst_n = 1'b1;

    pix_q = '{32'h00FF0000, 32'h0000FF00, 32'h000000FF};
    do_frame("rgb", 1'b0, 3, 0, 1'b0, -1, 1'b0);

    pix_q = '{32'hA5A5A5A5, 32'h00000001};
    do_frame("rgbw", 1'b1, 2, 0, 1'b0, -1, 1'b0);

    rand_pix(2);
    do_frame("underrun", 1'b1, 2, 32 * BITC + 500, 1'b0, 3000, 1'b1);

    rand_pix(5);
    do_frame("overrun", 1'b0, 5, 0, 1'b0, 1500, 1'b0);

    // Reset asserted while DO is high, part-way into the frame.
    rand_pix(3);
    sel = 1'b0; cur_n = 3; cur_b = 24;
    mon_clear(1'b0);
    start_frame();
    t_r = 0; i_r = 0; hit = 1'b0;
    while (!hit && t_r < 4000) begin
      valid = (i_r < 3);
      if (i_r < 3) data = pix_q[i_r];
      @(negedge clk);
      if (nbits >= 10 && do_m) hit = 1'b1;
      else begin
        if (valid && ready_m) i_r++;
        @(posedge clk); #1;
        t_r++;
      end
    end
    check_eq("reset_reach_mid_bit", int'(hit), 1);
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_do", int'(do_m), 0);
    check_eq("midrst_busy", int'(busy_m), 0);
    check_eq("midrst_ready", int'(ready_m), 0);
    check_eq("midrst_addr", int'(addr_m), 0);
    check_eq("midrst_under", int'(under_m), 0);
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    rand_pix(3);
    do_frame("post_reset", 1'b0, 3, 0, 1'b1, -1, 1'b0);

    rand_pix(2);
    do_frame("rand_b", 1'b1, 2, 0, 1'b1, 700, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
